// File: rtl/program_sequencer_pkg.sv
// Shared definitions for the AP instruction-path program sequencer:
// FSM state encodings and the fetch-address sentinel used while a jump is pending.
package program_sequencer_pkg;

    localparam logic [1:0] ST_START = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_JUMP  = 2'd2;
    localparam logic [1:0] ST_RET   = 2'd3;

    // Address with only the MSB set: parks the cache on a non-instruction address
    // while the vector load waits for AP_ctrl. Callers truncate to their width.
    function automatic logic [63:0] sentinel_addr(input int width);
        return 64'd1 << (width - 1);
    endfunction

endpackage

// File: rtl/program_sequencer_if.sv
// Handshake and address bus between AP_ctrl / instruction cache and the program sequencer.
// stack_err exists only when PC_STACK_ERR_EN is defined.
interface program_sequencer_if #(
    parameter int ADDR_WIDTH_MEM = 16,
    parameter int DDR_ADDR_WIDTH = 28,
    parameter int LOAD_W         = 10,
    parameter int STACK_DEPTH    = 4
);
    localparam int LVL_W = $clog2(STACK_DEPTH + 1);

    logic                      int_req;
    logic                      ret_valid;
    logic                      ins_inp_valid;
    logic                      ins_cache_rdy;
    logic                      ins_sent;
    logic [LOAD_W-1:0]         seg_loaded;
    logic [DDR_ADDR_WIDTH-1:0] jmp_addr;
    logic [ADDR_WIDTH_MEM-1:0] addr_ins;
    logic [ADDR_WIDTH_MEM-1:0] addr_cur_ins;
    logic                      int_ack;
    logic [LVL_W-1:0]          stack_level;
    logic                      done;
`ifdef PC_STACK_ERR_EN
    logic                      stack_err;
`endif

    modport master (
        output int_req, ret_valid, ins_inp_valid, ins_cache_rdy, ins_sent,
        output seg_loaded, jmp_addr,
        input  addr_ins, addr_cur_ins, int_ack, stack_level, done
`ifdef PC_STACK_ERR_EN
        , input stack_err
`endif
    );

    modport slave (
        input  int_req, ret_valid, ins_inp_valid, ins_cache_rdy, ins_sent,
        input  seg_loaded, jmp_addr,
        output addr_ins, addr_cur_ins, int_ack, stack_level, done
`ifdef PC_STACK_ERR_EN
        , output stack_err
`endif
    );

endinterface

// File: rtl/program_sequencer_pc_ret_stack.sv
// Return-address LIFO for nested interrupts. dout always shows the top entry
// (zero when empty). Callers never push and pop in the same cycle.
module pc_ret_stack #(
    parameter int STACK_DEPTH    = 4,
    parameter int ADDR_WIDTH_MEM = 16
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 push,
    input  logic                                 pop,
    input  logic [ADDR_WIDTH_MEM-1:0]            din,
    output logic [ADDR_WIDTH_MEM-1:0]            dout,
    output logic [$clog2(STACK_DEPTH+1)-1:0]     level,
    output logic                                 full,
    output logic                                 empty
);
    localparam int LVL_W = $clog2(STACK_DEPTH + 1);
    localparam int IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

    logic [ADDR_WIDTH_MEM-1:0] mem [STACK_DEPTH];
    logic [LVL_W-1:0]          level_q;
    logic [IDX_W-1:0]          wr_idx;
    logic [IDX_W-1:0]          top_idx;

    assign full    = (level_q == LVL_W'(STACK_DEPTH));
    assign empty   = (level_q == '0);
    assign level   = level_q;
    assign wr_idx  = IDX_W'(level_q);
    assign top_idx = IDX_W'(level_q - 1'b1);
    assign dout    = empty ? '0 : mem[top_idx];

    // Storage write on push; entries carry no reset, occupancy alone defines validity.
    always_ff @(posedge clk) begin
        if (push && !full) begin
            mem[wr_idx] <= din;
        end
    end

    // Occupancy counter; reset empties the stack.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            level_q <= '0;
        end else if (push && !full) begin
            level_q <= level_q + 1'b1;
        end else if (pop && !empty) begin
            level_q <= level_q - 1'b1;
        end
    end

endmodule

// File: rtl/program_sequencer.sv
// Program counter for the AP instruction path: issues fetch addresses, stalls at the
// edge of the resident cache segments, vectors to a DDR jump address on interrupt and
// returns through a nested return-address stack.
// Optional feature macro: PC_STACK_ERR_EN (sticky stack_err on refused int / empty ret).
module program_sequencer
    import program_sequencer_pkg::*;
#(
    parameter int ADDR_WIDTH_MEM  = 16,
    parameter int ISA_DEPTH       = 64,
    parameter int TOTAL_ISA_DEPTH = 128,
    parameter int DDR_ADDR_WIDTH  = 28,
    parameter int STACK_DEPTH     = 4,
    parameter int JMP_SHIFT       = 3,
    parameter int LOAD_W          = 10
) (
    input logic               clk,
    input logic               rst,
    program_sequencer_if.slave bus
);
    localparam int LVL_W = $clog2(STACK_DEPTH + 1);
    localparam int PW    = ADDR_WIDTH_MEM + LOAD_W;
    localparam logic [ADDR_WIDTH_MEM-1:0] LAST_ADDR = ADDR_WIDTH_MEM'(TOTAL_ISA_DEPTH - 1);
    localparam logic [ADDR_WIDTH_MEM-1:0] SENTINEL  = ADDR_WIDTH_MEM'(sentinel_addr(ADDR_WIDTH_MEM));

    logic [1:0]                state_q;
    logic [ADDR_WIDTH_MEM-1:0] addr_q;
    logic [ADDR_WIDTH_MEM-1:0] cur_q;
    logic                      ack_q;
    logic                      int_q;
    logic                      int_pend;

    logic                      int_rise;
    logic                      pend_eff;
    logic                      in_run;
    logic                      take_int;
    logic                      take_ret;
    logic                      can_adv;
    logic [PW-1:0]             next_pw;
    logic [PW-1:0]             seg_lim;
    logic [ADDR_WIDTH_MEM-1:0] vec_addr;
    logic [ADDR_WIDTH_MEM-1:0] stk_dout;
    logic [LVL_W-1:0]          stk_level;
    logic                      stk_full;
    logic                      stk_empty;
    logic                      unused_jmp;

    // A rising edge in the same cycle counts as pending, so it beats a coincident ret_valid.
    assign int_rise = bus.int_req & ~int_q;
    assign pend_eff = int_pend | int_rise;
    assign in_run   = (state_q == ST_RUN);
    assign take_int = in_run & pend_eff & ~stk_full;
    assign take_ret = in_run & ~take_int & bus.ret_valid & ~stk_empty;

    // Segment limit kept at full width so large seg_loaded values cannot alias small ones.
    assign next_pw = PW'(addr_q) + 1'b1;
    assign seg_lim = PW'(ISA_DEPTH) * PW'(bus.seg_loaded);
    assign can_adv = in_run & ~take_int & ~take_ret
                   & bus.ins_inp_valid & bus.ins_cache_rdy & bus.ins_sent
                   & (addr_q < LAST_ADDR) & (next_pw < seg_lim);

    assign vec_addr   = bus.jmp_addr[ADDR_WIDTH_MEM+JMP_SHIFT-1:JMP_SHIFT];
    assign unused_jmp = ^bus.jmp_addr;

    pc_ret_stack #(
        .STACK_DEPTH   (STACK_DEPTH),
        .ADDR_WIDTH_MEM(ADDR_WIDTH_MEM)
    ) u_stack (
        .clk  (clk),
        .rst  (rst),
        .push (take_int),
        .pop  (state_q == ST_RET),
        .din  (addr_q),
        .dout (stk_dout),
        .level(stk_level),
        .full (stk_full),
        .empty(stk_empty)
    );

    // Sequencer FSM, fetch/in-flight addresses, interrupt edge capture and ack pulse.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= ST_START;
            addr_q   <= '0;
            cur_q    <= '0;
            ack_q    <= 1'b0;
            int_q    <= 1'b0;
            int_pend <= 1'b0;
        end else begin
            int_q    <= bus.int_req;
            ack_q    <= 1'b0;
            int_pend <= take_int ? 1'b0 : pend_eff;
            case (state_q)
                ST_START: state_q <= ST_RUN;
                ST_RUN: begin
                    if (take_int) begin
                        addr_q  <= SENTINEL;
                        state_q <= ST_JUMP;
                    end else if (take_ret) begin
                        state_q <= ST_RET;
                    end else if (can_adv) begin
                        addr_q <= addr_q + 1'b1;
                        cur_q  <= addr_q + 1'b1;
                    end
                end
                ST_JUMP: begin
                    if (bus.ins_inp_valid) begin
                        addr_q  <= vec_addr;
                        cur_q   <= vec_addr;
                        ack_q   <= 1'b1;
                        state_q <= ST_RUN;
                    end else begin
                        addr_q <= SENTINEL;
                    end
                end
                ST_RET: begin
                    addr_q  <= stk_dout;
                    cur_q   <= stk_dout;
                    state_q <= ST_RUN;
                end
                default: state_q <= ST_START;
            endcase
        end
    end

`ifdef PC_STACK_ERR_EN
    logic err_q;
    logic refuse_int;
    logic bad_ret;

    assign refuse_int = in_run & pend_eff & stk_full;
    assign bad_ret    = in_run & ~take_int & bus.ret_valid & stk_empty;

    // Sticky misuse flag: interrupt refused on a full stack or return with nothing to pop.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_q <= 1'b0;
        end else if (refuse_int || bad_ret) begin
            err_q <= 1'b1;
        end
    end

    assign bus.stack_err = err_q;
`endif

    assign bus.addr_ins     = addr_q;
    assign bus.addr_cur_ins = cur_q;
    assign bus.int_ack      = ack_q;
    assign bus.stack_level  = stk_level;
    assign bus.done         = (addr_q == LAST_ADDR);

endmodule
